// File: rtl/sram_sp_mask_init.sv
// Single-port SRAM with per-segment write mask and a self-clearing sweep after reset.
// Accesses are accepted only once the sweep has zeroed every word (init_done high).
module sram_sp_mask_init #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 72,
  parameter int SEG_W   = 8,
  parameter int OUT_REG = 0,
  localparam int MASK_W = DATA_W / SEG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [MASK_W-1:0] RW0_wmask,
  input  logic [DATA_W-1:0] RW0_wdata,
  output logic [DATA_W-1:0] RW0_rdata,
  output logic              RW0_rvalid,
  output logic              init_done,
  output logic              dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata1_q;
  logic              rvalid1_q;
  logic              rd_fire, wr_fire;

  // Requests are only honoured in READY; during the sweep they are dropped.
  assign rd_fire = (state_q == ST_READY) && RW0_en && !RW0_wmode;
  assign wr_fire = (state_q == ST_READY) && RW0_en &&  RW0_wmode;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_ADDR) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      rvalid1_q <= 1'b0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rvalid1_q <= rd_fire;
      if (rd_fire) rdata1_q <= mem[RW0_addr];
    end
  end

  // Array has no reset; the sweep zeroes it one word per cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == ST_INIT) begin
        mem[cnt_q[ADDR_W-1:0]] <= '0;
      end else if (wr_fire) begin
        for (int i = 0; i < MASK_W; i++) begin
          if (RW0_wmask[i]) mem[RW0_addr][i*SEG_W +: SEG_W] <= RW0_wdata[i*SEG_W +: SEG_W];
        end
      end
    end
  end

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic [DATA_W-1:0] rdata2_q;
      logic              rvalid2_q;
      always_ff @(posedge clock) begin
        if (reset) begin
          rvalid2_q <= 1'b0;
          rdata2_q  <= '0;
        end else begin
          rvalid2_q <= rvalid1_q;
          if (rvalid1_q) rdata2_q <= rdata1_q;
        end
      end
      assign RW0_rdata  = rdata2_q;
      assign RW0_rvalid = rvalid2_q;
    end else begin : g_no_out_reg
      assign RW0_rdata  = rdata1_q;
      assign RW0_rvalid = rvalid1_q;
    end
  endgenerate

  assign init_done   = (state_q == ST_READY);
  assign dbg_state_o = state_q;

endmodule

// File: doc/sram_sp_mask_init.md
SRAM_SP_MASK_INIT -- requirements
Module: sram_sp_mask_init

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, address width; depth DEPTH = 2^ADDR_W.
REQ-002 SHALL provide parameter DATA_W, default 72, word width.
REQ-003 SHALL provide parameter SEG_W, default 8, write-mask granularity; DATA_W SHALL be a multiple of SEG_W; MASK_W = DATA_W/SEG_W.
REQ-004 SHALL provide parameter OUT_REG, default 0, legal 0/1; 1 adds an output pipeline register.
REQ-005 SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-006 clock  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 RW0_addr  input  ADDR_W  access address.
REQ-009 RW0_en  input  1  access request, sampled each cycle.
REQ-010 RW0_wmode  input  1  1 = write, 0 = read.
REQ-011 RW0_wmask  input  MASK_W  per-segment write enable; bit i covers wdata[i*SEG_W +: SEG_W].
REQ-012 RW0_wdata  input  DATA_W  write data.
REQ-013 RW0_rdata  output  DATA_W  read data.
REQ-014 RW0_rvalid  output  1  one-cycle pulse marking new RW0_rdata.
REQ-015 init_done  output  1  high once array clear is complete; accesses accepted only while high.

Function
REQ-016 SHALL implement a two-state FSM: INIT, READY.
REQ-017 Reset SHALL enter INIT with clear counter = 0.
REQ-018 In INIT, SHALL write all-zero to address = counter each cycle, increment counter; after address DEPTH-1 is written, SHALL enter READY next cycle.
REQ-019 INIT SHALL last exactly DEPTH cycles after reset deassertion; init_done SHALL rise in cycle DEPTH (reset deasserted at cycle 0).
REQ-020 In INIT, RW0_en SHALL be ignored: no array write, no read, no rvalid; requests are dropped, not queued.
REQ-021 Counter SHALL be ADDR_W+1 bits, or INIT SHALL otherwise terminate on the last address; it SHALL not wrap back into a second sweep.
REQ-022 In READY, write (en=1, wmode=1) SHALL update only segments with wmask bit set; other segments retain their value; wmask = 0 is a legal no-op.
REQ-023 Writes SHALL NOT change RW0_rdata or pulse RW0_rvalid.
REQ-024 In READY, a read (en=1, wmode=0) sampled at edge N SHALL present ram[addr] with rvalid=1 after edge N+1+OUT_REG.
REQ-025 Back-to-back reads SHALL be accepted every cycle; rvalid SHALL stay high for consecutive results; throughput one read per cycle.
REQ-026 Read data SHALL reflect all writes sampled at earlier edges.
REQ-027 RW0_rdata SHALL hold the last read value while no new read completes; no random or garbage output.
REQ-028 The FSM SHALL not return to INIT except via reset.

Reset
REQ-029 In the cycle after reset is sampled: RW0_rdata = 0, RW0_rvalid = 0, init_done = 0, counter = 0, state = INIT.
REQ-030 Reset during INIT SHALL restart the sweep at address 0; a full DEPTH cycles SHALL elapse before init_done.
REQ-031 Reset in READY SHALL discard in-flight reads, pipeline stage included; no rvalid after reset.
REQ-032 Array contents are undefined during reset assertion; they SHALL be all zero once init_done rises.

Verification
REQ-033 Defaults. Release reset at cycle 0: init_done=0 through cycle 255, 1 at cycle 256. Then read 0x00, 0x7F and 0xFF: each returns 72'h0 with rvalid one cycle later.
REQ-034 Write 0x05 = 72'hFF_0123456789ABCDEF with mask 9'h1FF, then read 0x05 next cycle: rdata = 72'hFF_0123456789ABCDEF. Then idle 3 cycles: rdata holds, rvalid=0.
REQ-035 Build on REQ-034. Write 0x05 = 72'h00_00000000000000AA with mask 9'h001, then read: rdata = 72'hFF_0123456789ABCDAA.
REQ-036 Drive write 0x10 = all-ones (mask all) during INIT at cycle 10. After init_done, read 0x10: rdata = 0. No rvalid at any point during INIT.
REQ-037 OUT_REG=1. Write 0x01=1, 0x02=2, 0x03=3. Reads on 3 consecutive cycles N..N+2: rvalid high at N+2..N+4 with data 1, 2, 3.
REQ-038 Assert reset at cycle 100 of INIT, release at 101: init_done stays 0 until 256 cycles after release. Separately, reset during a pending OUT_REG=1 read: no rvalid afterward.
